// File: rtl/unit_fault_sequencer.sv
// -----------------------------------------------------------------------------
// unit_fault_sequencer
//
// Sequences the power unit's response to a latched unit fault. The block
// gates PWM, commands the bypass contactor (drives the detector's BypCon)
// and issues the detector's reset_unit clear pulse when the operator asks
// for a fault reset.
//
// Build option:
//   UNIT_AUTO_BYPASS_EN - when defined, TRIP moves on to the bypass sequence
//                         (BYP_WAIT -> BYPASSED / BYP_FAIL) after BLOCK_US
//                         microsecond ticks. When undefined, TRIP only exits
//                         on an operator reset and byp_cmd/byp_fail are 0.
//
// Parameters:
//   BLOCK_US       - us ticks spent in TRIP before the bypass command (1..65535)
//   BYP_TIMEOUT_MS - ms ticks allowed for BypOK after the command   (1..65535)
//   RST_PULSE      - reset_unit pulse width in clk cycles            (1..255)
//
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   time_1us     - 1 us square wave (rising edge used, synchronized)
//   time_1ms     - 1 ms square wave (rising edge used, synchronized)
//   start_stop   - run command level, same clock domain
//   reset_req    - operator fault reset (rising edge used, synchronized)
//   err_unit     - latched unit fault, same clock domain
//   err_info     - 11-bit detector fault word, same clock domain
//   BypOK        - bypass contactor closed feedback (synchronized level)
//   pwm_en       - PWM enable, high only in RUN
//   byp_cmd      - bypass close command, high in BYP_WAIT/BYPASSED/BYP_FAIL
//   reset_unit   - fault clear pulse, high only in CLEAR
//   byp_fail     - bypass did not close in time, high only in BYP_FAIL
//   state        - current FSM state
//   trip_info    - snapshot of err_info taken on TRIP entry
// -----------------------------------------------------------------------------
module unit_fault_sequencer #(
  parameter int unsigned BLOCK_US       = 10,
  parameter int unsigned BYP_TIMEOUT_MS = 60,
  parameter int unsigned RST_PULSE      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        time_1us,
  input  logic        time_1ms,
  input  logic        start_stop,
  input  logic        reset_req,
  input  logic        err_unit,
  input  logic [10:0] err_info,
  input  logic        BypOK,
  output logic        pwm_en,
  output logic        byp_cmd,
  output logic        reset_unit,
  output logic        byp_fail,
  output logic [2:0]  state,
  output logic [10:0] trip_info
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_TRIP     = 3'd2,
    ST_BYP_WAIT = 3'd3,
    ST_BYPASSED = 3'd4,
    ST_BYP_FAIL = 3'd5,
    ST_CLEAR    = 3'd6
  } state_e;

  // Last value of the CLEAR cycle counter before returning to IDLE.
  localparam logic [7:0] CLR_LAST_C = 8'(RST_PULSE - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // Bit 0 is the first synchronizer flop, bit 1 the synchronized value and
  // bit 2 the previous synchronized value used for rising-edge detection.
  // ---------------------------------------------------------------------------
  logic [2:0] us_pipe_q;
  logic [2:0] ms_pipe_q;
  logic [2:0] rr_pipe_q;
  logic [1:0] bo_pipe_q;

  logic us_tick_s;
  logic ms_tick_s;
  logic rr_edge_s;
  logic bypok_s;

  // Two-flop synchronizers plus the edge-detect delay stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_pipe_q <= 3'b000;
      ms_pipe_q <= 3'b000;
      rr_pipe_q <= 3'b000;
      bo_pipe_q <= 2'b00;
    end else begin
      us_pipe_q <= {us_pipe_q[1:0], time_1us};
      ms_pipe_q <= {ms_pipe_q[1:0], time_1ms};
      rr_pipe_q <= {rr_pipe_q[1:0], reset_req};
      bo_pipe_q <= {bo_pipe_q[0], BypOK};
    end
  end

  // Rising edge = synchronized value 1 while the previous value was 0.
  assign us_tick_s = us_pipe_q[1] & ~us_pipe_q[2];
  assign ms_tick_s = ms_pipe_q[1] & ~ms_pipe_q[2];
  assign rr_edge_s = rr_pipe_q[1] & ~rr_pipe_q[2];
  assign bypok_s   = bo_pipe_q[1];

  // ---------------------------------------------------------------------------
  // FSM state, counters and registered outputs
  // ---------------------------------------------------------------------------
  state_e      state_q;
  state_e      state_d;
  logic [10:0] trip_info_q;
  logic        pwm_en_q;
  logic        reset_unit_q;
  logic [7:0]  clr_cnt_q;
  logic        enter_trip_s;
  logic        enter_clr_s;

`ifdef UNIT_AUTO_BYPASS_EN
  localparam logic [15:0] BLOCK_US_C = 16'(BLOCK_US);
  localparam logic [15:0] BYP_TO_C   = 16'(BYP_TIMEOUT_MS);

  logic [15:0] us_cnt_q;
  logic [15:0] ms_cnt_q;
  logic [15:0] us_cnt_inc_s;
  logic [15:0] ms_cnt_inc_s;
  logic        byp_cmd_q;
  logic        byp_fail_q;

  // Saturating increments; the compare below uses the incremented value so
  // the transition lands on the clock of the counted tick itself.
  assign us_cnt_inc_s = (us_cnt_q == 16'hFFFF) ? us_cnt_q : (us_cnt_q + 16'd1);
  assign ms_cnt_inc_s = (ms_cnt_q == 16'hFFFF) ? ms_cnt_q : (ms_cnt_q + 16'd1);
`else
  // Tick/feedback paths and timing parameters have no consumer without the
  // bypass sequence; fold them into one sink so the intent is explicit.
  logic unused_s;
  assign unused_s = ^{us_tick_s, ms_tick_s, bypok_s,
                      16'(BLOCK_US), 16'(BYP_TIMEOUT_MS)};
`endif

  // Next-state decode; priorities follow the listed order in each state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (err_unit) begin
          state_d = ST_TRIP;
        end else if (rr_edge_s) begin
          state_d = ST_CLEAR;
        end else if (start_stop) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (err_unit) begin
          state_d = ST_TRIP;
        end else if (!start_stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_TRIP: begin
        // Operator reset wins over the block time expiring in the same cycle.
        if (rr_edge_s) begin
          state_d = ST_CLEAR;
`ifdef UNIT_AUTO_BYPASS_EN
        end else if (us_tick_s && (us_cnt_inc_s == BLOCK_US_C)) begin
          state_d = ST_BYP_WAIT;
`endif
        end else begin
          state_d = ST_TRIP;
        end
      end
`ifdef UNIT_AUTO_BYPASS_EN
      ST_BYP_WAIT: begin
        // Contactor feedback wins over a simultaneous timeout.
        if (bypok_s) begin
          state_d = ST_BYPASSED;
        end else if (ms_tick_s && (ms_cnt_inc_s == BYP_TO_C)) begin
          state_d = ST_BYP_FAIL;
        end else begin
          state_d = ST_BYP_WAIT;
        end
      end
      ST_BYPASSED: begin
        state_d = ST_BYPASSED;
      end
      ST_BYP_FAIL: begin
        state_d = ST_BYP_FAIL;
      end
`endif
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST_C) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        // Unused encodings (and bypass states when bypass is not built)
        // fall back to the safe state with PWM blocked.
        state_d = ST_TRIP;
      end
    endcase
  end

  assign enter_trip_s = (state_d == ST_TRIP)  && (state_q != ST_TRIP);
  assign enter_clr_s  = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);

  // State register, outputs decoded from next state, snapshot and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      trip_info_q  <= 11'd0;
      pwm_en_q     <= 1'b0;
      reset_unit_q <= 1'b0;
      clr_cnt_q    <= 8'd0;
`ifdef UNIT_AUTO_BYPASS_EN
      us_cnt_q     <= 16'd0;
      ms_cnt_q     <= 16'd0;
      byp_cmd_q    <= 1'b0;
      byp_fail_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pwm_en_q     <= (state_d == ST_RUN);
      reset_unit_q <= (state_d == ST_CLEAR);

      if (enter_trip_s) begin
        trip_info_q <= err_info;
      end else if (enter_clr_s) begin
        trip_info_q <= 11'd0;
      end else begin
        trip_info_q <= trip_info_q;
      end

      // Held at zero outside CLEAR, so it starts from zero on entry.
      if (state_q != ST_CLEAR) begin
        clr_cnt_q <= 8'd0;
      end else if (clr_cnt_q != 8'hFF) begin
        clr_cnt_q <= clr_cnt_q + 8'd1;
      end else begin
        clr_cnt_q <= clr_cnt_q;
      end

`ifdef UNIT_AUTO_BYPASS_EN
      // byp_cmd stays high across all three bypass states so the detector
      // sees exactly one BypCon rising edge.
      byp_cmd_q  <= (state_d == ST_BYP_WAIT) || (state_d == ST_BYPASSED) ||
                    (state_d == ST_BYP_FAIL);
      byp_fail_q <= (state_d == ST_BYP_FAIL);

      if (state_q != ST_TRIP) begin
        us_cnt_q <= 16'd0;
      end else if (us_tick_s) begin
        us_cnt_q <= us_cnt_inc_s;
      end else begin
        us_cnt_q <= us_cnt_q;
      end

      if (state_q != ST_BYP_WAIT) begin
        ms_cnt_q <= 16'd0;
      end else if (ms_tick_s) begin
        ms_cnt_q <= ms_cnt_inc_s;
      end else begin
        ms_cnt_q <= ms_cnt_q;
      end
`endif
    end
  end

  assign pwm_en     = pwm_en_q;
  assign reset_unit = reset_unit_q;
  assign state      = state_q;
  assign trip_info  = trip_info_q;
`ifdef UNIT_AUTO_BYPASS_EN
  assign byp_cmd    = byp_cmd_q;
  assign byp_fail   = byp_fail_q;
`else
  assign byp_cmd    = 1'b0;
  assign byp_fail   = 1'b0;
`endif

endmodule

// File: tb/tb_unit_fault_sequencer.sv
// -----------------------------------------------------------------------------
// tb_unit_fault_sequencer
//
// Directed bench for unit_fault_sequencer. A state-level model of the
// sequencing rules runs alongside the DUT and is compared every cycle;
// directed scenarios add literal expectations for latency, pulse width,
// tick counts and asynchronous reset. Inputs change 1 ns after the falling
// clock edge; the DUT samples on the rising edge.
// One "us" of the bench is 8 clk cycles and one "ms" is 16 clk cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unit_fault_sequencer;

  localparam int BLOCK_US       = 10;
  localparam int BYP_TIMEOUT_MS = 60;
  localparam int RST_PULSE      = 8;
`ifdef UNIT_AUTO_BYPASS_EN
  localparam bit BYP_ON = 1'b1;
`else
  localparam bit BYP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        time_1us = 1'b0;
  logic        time_1ms = 1'b0;
  logic        start_stop = 1'b0;
  logic        reset_req = 1'b0;
  logic        err_unit = 1'b0;
  logic [10:0] err_info = 11'd0;
  logic        BypOK = 1'b0;
  logic        pwm_en;
  logic        byp_cmd;
  logic        reset_unit;
  logic        byp_fail;
  logic [2:0]  state;
  logic [10:0] trip_info;

  int checks = 0;
  int errors = 0;

  unit_fault_sequencer #(
    .BLOCK_US      (BLOCK_US),
    .BYP_TIMEOUT_MS(BYP_TIMEOUT_MS),
    .RST_PULSE     (RST_PULSE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .time_1us  (time_1us),
    .time_1ms  (time_1ms),
    .start_stop(start_stop),
    .reset_req (reset_req),
    .err_unit  (err_unit),
    .err_info  (err_info),
    .BypOK     (BypOK),
    .pwm_en    (pwm_en),
    .byp_cmd   (byp_cmd),
    .reset_unit(reset_unit),
    .byp_fail  (byp_fail),
    .state     (state),
    .trip_info (trip_info)
  );

  always #5 clk = ~clk;

  // Free-running tick sources: us period 8 cycles, ms period 16 cycles.
  int tcnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      tcnt++;
      time_1us = tcnt[2];
      time_1ms = tcnt[3];
    end
  end

  // Watchdog: the scenarios are all bounded, this only catches a hang.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: state number, events seen since state entry, snapshot.
  // Event rule: a source change becomes an event on the 3rd rising clk edge
  // after it is applied (2 synchronizer cycles + 1 edge-detect cycle); the
  // BypOK level is seen on the 3rd edge as well.
  // ---------------------------------------------------------------------------
  int          m_state = 0;
  int          m_prev;
  int          m_next;
  int          m_dwell = 0;
  logic [10:0] m_trip = 11'd0;
  logic [2:0]  hu = 3'b000, hm = 3'b000, hr = 3'b000, hb = 3'b000;
  logic        us_ev, ms_ev, rr_ev, bo_lvl;
  logic [17:0] exp_v, act_v;

  // Model step plus per-cycle compare; runs at each falling edge, when the
  // inputs still hold the values the DUT sampled on the preceding rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        m_state = 0;
        m_dwell = 0;
        m_trip  = 11'd0;
        hu = 3'b000; hm = 3'b000; hr = 3'b000; hb = 3'b000;
      end else begin
        us_ev  = hu[1] & ~hu[2];
        ms_ev  = hm[1] & ~hm[2];
        rr_ev  = hr[1] & ~hr[2];
        bo_lvl = hb[1];
        hu = {hu[1:0], time_1us};
        hm = {hm[1:0], time_1ms};
        hr = {hr[1:0], reset_req};
        hb = {hb[1:0], BypOK};
        m_prev = m_state;
        m_next = m_state;
        case (m_prev)
          0: begin
            if (err_unit) m_next = 2;
            else if (rr_ev) m_next = 6;
            else if (start_stop) m_next = 1;
          end
          1: begin
            if (err_unit) m_next = 2;
            else if (!start_stop) m_next = 0;
          end
          2: begin
            if (rr_ev) m_next = 6;
            else if (BYP_ON && us_ev) begin
              m_dwell++;
              if (m_dwell == BLOCK_US) m_next = 3;
            end
          end
          3: begin
            if (bo_lvl) m_next = 4;
            else if (ms_ev) begin
              m_dwell++;
              if (m_dwell == BYP_TIMEOUT_MS) m_next = 5;
            end
          end
          6: begin
            m_dwell++;
            if (m_dwell == RST_PULSE) m_next = 0;
          end
          default: m_next = m_prev;
        endcase
        if (m_next == 2 && m_prev != 2) m_trip = err_info;
        else if (m_next == 6 && m_prev != 6) m_trip = 11'd0;
        if (m_next != m_prev) m_dwell = 0;
        m_state = m_next;
      end
      exp_v = {3'(m_state), (m_state == 1), (m_state >= 3 && m_state <= 5),
               (m_state == 6), (m_state == 5), m_trip};
      act_v = {state, pwm_en, byp_cmd, reset_unit, byp_fail, trip_info};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        if (errors < 30)
          $display("FAIL cycle_model t=%0t: dut st=%0d pwm=%b byp=%b rst=%b bf=%b ti=%h, model st=%0d pwm=%b byp=%b rst=%b bf=%b ti=%h",
                   $time, act_v[17:15], act_v[14], act_v[13], act_v[12], act_v[11], act_v[10:0],
                   exp_v[17:15], exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10:0]);
      end
    end
  end

  // Raise reset_req and measure latency to reset_unit and its width.
  task automatic do_clear(output int lat, output int width, output logic [10:0] ti_first);
    reset_req = 1'b1;
    lat = 0;
    width = 0;
    ti_first = 11'h7FF;
    while (reset_unit !== 1'b1 && lat < 20) begin
      cyc(1);
      lat++;
    end
    ti_first = trip_info;
    reset_req = 1'b0;
    while (reset_unit === 1'b1 && width < 300) begin
      cyc(1);
      width++;
    end
  endtask

  // Drop rst_n between clock edges and check outputs clear immediately.
  task automatic async_rst(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    chk(name, 32'({state, pwm_en, byp_cmd, reset_unit, byp_fail, trip_info}), 32'd0);
    cyc(2);
    err_unit   = 1'b0;
    start_stop = 1'b0;
    BypOK      = 1'b0;
    reset_req  = 1'b0;
    rst_n      = 1'b1;
    cyc(2);
  endtask

  int          lat, width, n;
  logic [10:0] ti0;
  logic        hold_ok;

  initial begin
    cyc(3);
    chk("reset_values", 32'({state, pwm_en, byp_cmd, reset_unit, byp_fail, trip_info}), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Clean run and stop.
    start_stop = 1'b1;
    cyc(1);
    chk("run_state", 32'(state), 32'd1);
    chk("run_pwm", 32'(pwm_en), 32'd1);
    start_stop = 1'b0;
    cyc(1);
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_pwm", 32'(pwm_en), 32'd0);

    // Fault together with start in IDLE goes straight to TRIP.
    err_info   = 11'h123;
    err_unit   = 1'b1;
    start_stop = 1'b1;
    cyc(1);
    chk("idle_err_start_state", 32'(state), 32'd2);
    chk("idle_err_start_info", 32'(trip_info), 32'h123);
    err_unit   = 1'b0;
    start_stop = 1'b0;
    do_clear(lat, width, ti0);
    chk("clr1_latency", 32'(lat), 32'd3);
    chk("clr1_width", 32'(width), 32'd8);
    chk("clr1_info_zero", 32'(ti0), 32'd0);
    chk("clr1_idle", 32'(state), 32'd0);

    // Reset request in IDLE also produces a clear pulse.
    do_clear(lat, width, ti0);
    chk("clr_idle_width", 32'(width), 32'd8);
    chk("clr_idle_state", 32'(state), 32'd0);

    // Reset in TRIP around us tick 4, fault still present.
    start_stop = 1'b1;
    cyc(2);
    chk("run2_pwm", 32'(pwm_en), 32'd1);
    err_info = 11'h2AA;
    err_unit = 1'b1;
    cyc(1);
    chk("trip_pwm_latency", 32'(pwm_en), 32'd0);
    chk("trip_info_2aa", 32'(trip_info), 32'h2AA);
    cyc(29);
    chk("trip_hold_before_clear", 32'(state), 32'd2);
    do_clear(lat, width, ti0);
    chk("clr2_latency", 32'(lat), 32'd3);
    chk("clr2_width", 32'(width), 32'd8);
    chk("clr2_info_zero", 32'(ti0), 32'd0);
    chk("clr2_idle", 32'(state), 32'd0);
    err_info = 11'h155;
    cyc(1);
    chk("retrip_state", 32'(state), 32'd2);
    chk("retrip_info", 32'(trip_info), 32'h155);
    err_unit   = 1'b0;
    start_stop = 1'b0;
    do_clear(lat, width, ti0);
    chk("clr3_width", 32'(width), 32'd8);
    cyc(2);
    chk("clr3_idle_stays", 32'(state), 32'd0);

`ifdef UNIT_AUTO_BYPASS_EN
    // Trip followed by a successful bypass.
    start_stop = 1'b1;
    cyc(2);
    err_info = 11'h040;
    err_unit = 1'b1;
    cyc(1);
    chk("byp_pwm_off", 32'(pwm_en), 32'd0);
    chk("byp_trip_info", 32'(trip_info), 32'h040);
    err_info = 11'h7FF;
    n = 0;
    while (byp_cmd !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    chk_rng("bypass_cmd_delay", n, 73, 80);
    chk("bypass_wait_state", 32'(state), 32'd3);
    chk("bypass_info_held", 32'(trip_info), 32'h040);
    cyc(80);
    BypOK = 1'b1;
    cyc(2);
    chk("bypok_sync_wait", 32'(state), 32'd3);
    cyc(1);
    chk("bypassed_state", 32'(state), 32'd4);
    chk("bypassed_fail", 32'(byp_fail), 32'd0);
    chk("bypassed_cmd", 32'(byp_cmd), 32'd1);
    async_rst("async_rst_bypassed");

    // Bypass timeout.
    start_stop = 1'b1;
    cyc(2);
    err_unit = 1'b1;
    cyc(1);
    n = 0;
    while (byp_cmd !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    chk_rng("bypass2_cmd_delay", n, 73, 80);
    n = 0;
    while (state !== 3'd5 && n < 1200) begin
      cyc(1);
      n++;
    end
    chk_rng("bypass_timeout_delay", n, 945, 960);
    chk("byp_fail_flag", 32'(byp_fail), 32'd1);
    chk("byp_fail_cmd", 32'(byp_cmd), 32'd1);
    reset_req = 1'b1;
    cyc(5);
    reset_req = 1'b0;
    BypOK = 1'b1;
    cyc(8);
    chk("byp_fail_terminal", 32'(state), 32'd5);
    chk("byp_fail_no_clear", 32'(reset_unit), 32'd0);
    async_rst("async_rst_byp_fail");
`else
    // Without auto bypass TRIP holds for 1000 us.
    err_info = 11'h040;
    err_unit = 1'b1;
    cyc(1);
    chk("nobyp_trip_info", 32'(trip_info), 32'h040);
    hold_ok = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      cyc(1);
      if (state !== 3'd2 || byp_cmd !== 1'b0) hold_ok = 1'b0;
    end
    chk("nobyp_trip_hold", 32'(hold_ok), 32'd1);
    err_unit = 1'b0;
    do_clear(lat, width, ti0);
    chk("nobyp_clr_latency", 32'(lat), 32'd3);
    chk("nobyp_clr_width", 32'(width), 32'd8);
    chk("nobyp_idle", 32'(state), 32'd0);
    err_unit = 1'b1;
    cyc(1);
    chk("nobyp_trip_again", 32'(state), 32'd2);
    async_rst("async_rst_trip");
`endif

    cyc(3);
    chk("final_idle", 32'(state), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
